// File: rtl/fft_peak_detect.sv
// FFT output peak detector: buffers a 16-bin frame, scans one bin per cycle for
// the largest re^2+im^2, and reports its index and power with a one-cycle done.
module fft_peak_detect #(
  parameter int DATA_W  = 16,
  parameter bit SKIP_DC = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fft_valid,
  input  logic [2*DATA_W-1:0] fft_d0,
  input  logic [2*DATA_W-1:0] fft_d1,
  input  logic [2*DATA_W-1:0] fft_d2,
  input  logic [2*DATA_W-1:0] fft_d3,
  input  logic [2*DATA_W-1:0] fft_d4,
  input  logic [2*DATA_W-1:0] fft_d5,
  input  logic [2*DATA_W-1:0] fft_d6,
  input  logic [2*DATA_W-1:0] fft_d7,
  input  logic [2*DATA_W-1:0] fft_d8,
  input  logic [2*DATA_W-1:0] fft_d9,
  input  logic [2*DATA_W-1:0] fft_d10,
  input  logic [2*DATA_W-1:0] fft_d11,
  input  logic [2*DATA_W-1:0] fft_d12,
  input  logic [2*DATA_W-1:0] fft_d13,
  input  logic [2*DATA_W-1:0] fft_d14,
  input  logic [2*DATA_W-1:0] fft_d15,
  output logic                done,
  output logic [3:0]          freq,
  output logic [2*DATA_W-1:0] peak_mag,
  output logic                busy,
  output logic                overrun
);
  localparam int W = 2 * DATA_W;
  localparam logic [3:0] FIRST = SKIP_DC ? 4'd1 : 4'd0;

  typedef enum logic {IDLE, SCAN} state_t;
  state_t state, state_nxt;

  logic [15:0][W-1:0] din, frame, pend;
  logic               pend_vld;
  logic [3:0]         k;
  logic               last, cand, take;
  logic signed [W-1:0] re_x, im_x;
  logic [W-1:0]       mag, max_mag, best_mag;
  logic [3:0]         max_idx, best_idx;

  assign din = {fft_d15, fft_d14, fft_d13, fft_d12, fft_d11, fft_d10, fft_d9, fft_d8,
                fft_d7, fft_d6, fft_d5, fft_d4, fft_d3, fft_d2, fft_d1, fft_d0};

  assign last = (state == SCAN) && (k == 4'd15);
  assign busy = (state == SCAN);

  // Sign-extend before multiplying so the full-width product is exact.
  assign re_x = W'(signed'(frame[k][W-1:DATA_W]));
  assign im_x = W'(signed'(frame[k][DATA_W-1:0]));
  assign mag  = re_x * re_x + im_x * im_x;

  // First candidate seeds the running max; later bins replace only on strict >.
  assign cand     = !(SKIP_DC && (k == 4'd0));
  assign take     = (k == FIRST) || (mag > max_mag);
  assign best_mag = take ? mag : max_mag;
  assign best_idx = take ? k : max_idx;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (fft_valid) state_nxt = SCAN;
      SCAN: if (last && !fft_valid && !pend_vld) state_nxt = IDLE;
    endcase
  end

  // Bin storage carries no reset; only the control that qualifies it does.
  always_ff @(posedge clk) begin
    if (state == IDLE) begin
      if (fft_valid) frame <= din;
    end else if (last) begin
      if (fft_valid)     frame <= din;
      else if (pend_vld) frame <= pend;
    end else if (fft_valid) begin
      pend <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      k        <= 4'd0;
      pend_vld <= 1'b0;
      done     <= 1'b0;
      overrun  <= 1'b0;
      freq     <= 4'd0;
      peak_mag <= '0;
      max_mag  <= '0;
      max_idx  <= 4'd0;
    end else begin
      done    <= 1'b0;
      overrun <= 1'b0;
      if (state == IDLE) begin
        k <= 4'd0;
      end else begin
        k <= k + 4'd1;
        if (cand) begin
          max_mag <= best_mag;
          max_idx <= best_idx;
        end
        if (last) begin
          done     <= 1'b1;
          freq     <= best_idx;
          peak_mag <= best_mag;
          if (!fft_valid && pend_vld) pend_vld <= 1'b0;
        end else if (fft_valid) begin
          pend_vld <= 1'b1;
          overrun  <= pend_vld;
        end
      end
    end
  end
endmodule
